// File: rtl/mem_arbiter_line.sv
// mem_arbiter_line
//   Arbitrates three memory clients onto a byte-wide RAM port with fixed
//   priority store > load > icache line fetch. Multi-byte accesses are
//   serialised little-endian; loads are assembled with sign/zero extension;
//   fetches fill a LINE_BYTES-wide line buffer.
//
// Parameters
//   LINE_BYTES : icache line size in bytes (power of two, 4..128)
//   ADDR_W     : address width
//
// Optional feature macro
//   MEM_IO_STALL_EN : when defined, a store to IO space (st_addr[17:16]==2'b11)
//                     is held off in IDLE while io_full is high, and it blocks
//                     lower-priority requests meanwhile. Undefined: io_full is
//                     ignored.
//
// Ports
//   clk, rst (async, active low), rdy (global enable, low freezes everything)
//   fetch_req/fetch_addr -> fetch_done pulse, fetch_line
//   st_req/st_addr/st_data/st_size -> st_done pulse
//   ld_req/ld_addr/ld_size/ld_signed -> ld_done pulse, ld_data
//   io_full : IO output buffer full
//   mem_din, mem_dout, mem_a, mem_wr : byte RAM port (read latency 1)
//   dbg_state : current FSM state encoding
//
// Handshake: each *_req is a level held by the client until its *_done
// pulse; the request fields are sampled only on the accepting edge, the
// done pulse lasts one enabled cycle, and the following GAP cycle never
// accepts so the client can drop its request without a second accept.
module mem_arbiter_line #(
  parameter int LINE_BYTES = 64,
  parameter int ADDR_W     = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic                    fetch_req,
  input  logic [ADDR_W-1:0]       fetch_addr,
  output logic                    fetch_done,
  output logic [8*LINE_BYTES-1:0] fetch_line,
  input  logic                    st_req,
  input  logic [ADDR_W-1:0]       st_addr,
  input  logic [31:0]             st_data,
  input  logic [1:0]              st_size,
  output logic                    st_done,
  input  logic                    ld_req,
  input  logic [ADDR_W-1:0]       ld_addr,
  input  logic [1:0]              ld_size,
  input  logic                    ld_signed,
  output logic                    ld_done,
  output logic [31:0]             ld_data,
  input  logic                    io_full,
  input  logic [7:0]              mem_din,
  output logic [7:0]              mem_dout,
  output logic [ADDR_W-1:0]       mem_a,
  output logic                    mem_wr,
  output logic [2:0]              dbg_state
);

  localparam int CNT_W = $clog2(LINE_BYTES);
  localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(LINE_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_STORE = 3'd1,
    S_LOAD  = 3'd2,
    S_FETCH = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;     // index of the byte in flight
  logic [CNT_W-1:0]    last_q, last_d;   // index of the final byte
  logic [ADDR_W-1:0]   addr_q, addr_d;   // latched base address
  logic [31:0]         data_q, data_d;   // latched store data
  logic [1:0]          size_q, size_d;
  logic                signed_q, signed_d;
  logic [23:0]         ld_buf_q, ld_buf_d; // load bytes 0..2 already captured

  logic                    fetch_done_d, st_done_d, ld_done_d, mem_wr_d;
  logic [8*LINE_BYTES-1:0] fetch_line_d;
  logic [31:0]             ld_data_d;
  logic [7:0]              mem_dout_d;
  logic [ADDR_W-1:0]       mem_a_d;

  logic [CNT_W-1:0]  cnt_nx;
  logic [ADDR_W-1:0] addr_nx;
  logic              io_block;

  assign cnt_nx  = cnt_q + 1'b1;
  assign addr_nx = addr_q + ADDR_W'(cnt_nx);  // wraps modulo 2^ADDR_W
  assign dbg_state = state_q;

`ifdef MEM_IO_STALL_EN
  assign io_block = st_req && (st_addr[17:16] == 2'b11) && io_full;
`else
  logic unused_io_full;
  assign unused_io_full = io_full;
  assign io_block = 1'b0;
`endif

  function automatic logic [CNT_W-1:0] last_idx(input logic [1:0] size);
    case (size)
      2'd0:    return CNT_W'(0);
      2'd1:    return CNT_W'(1);
      default: return CNT_W'(3);
    endcase
  endfunction

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_d       = last_q;
    addr_d       = addr_q;
    data_d       = data_q;
    size_d       = size_q;
    signed_d     = signed_q;
    ld_buf_d     = ld_buf_q;
    fetch_done_d = 1'b0;
    st_done_d    = 1'b0;
    ld_done_d    = 1'b0;
    mem_wr_d     = mem_wr;
    fetch_line_d = fetch_line;
    ld_data_d    = ld_data;
    mem_dout_d   = mem_dout;
    mem_a_d      = mem_a;

    case (state_q)
      S_IDLE: begin
        // An IO store held off by io_full still wins priority, so it
        // blocks the load and fetch paths too.
        if (st_req && !io_block) begin
          state_d    = S_STORE;
          addr_d     = st_addr;
          data_d     = st_data;
          last_d     = last_idx(st_size);
          cnt_d      = '0;
          mem_a_d    = st_addr;
          mem_dout_d = st_data[7:0];
          mem_wr_d   = 1'b1;
        end else if (!st_req && ld_req) begin
          state_d  = S_LOAD;
          addr_d   = ld_addr;
          size_d   = ld_size;
          signed_d = ld_signed;
          last_d   = last_idx(ld_size);
          cnt_d    = '0;
          mem_a_d  = ld_addr;
          mem_wr_d = 1'b0;
        end else if (!st_req && fetch_req) begin
          state_d  = S_FETCH;
          addr_d   = fetch_addr & ~LINE_MASK;
          last_d   = CNT_W'(LINE_BYTES - 1);
          cnt_d    = '0;
          mem_a_d  = fetch_addr & ~LINE_MASK;
          mem_wr_d = 1'b0;
        end
      end

      S_STORE: begin
        if (cnt_q == last_q) begin
          mem_wr_d  = 1'b0;
          st_done_d = 1'b1;
          state_d   = S_GAP;
        end else begin
          cnt_d      = cnt_nx;
          mem_a_d    = addr_nx;
          mem_dout_d = data_q[{cnt_nx[1:0], 3'b000} +: 8];
        end
      end

      S_LOAD: begin
        // mem_din holds the byte addressed on the previous edge.
        if (cnt_q == last_q) begin
          case (size_q)
            2'd0:    ld_data_d = {{24{signed_q & mem_din[7]}}, mem_din};
            2'd1:    ld_data_d = {{16{signed_q & mem_din[7]}}, mem_din, ld_buf_q[7:0]};
            default: ld_data_d = {mem_din, ld_buf_q};
          endcase
          ld_done_d = 1'b1;
          state_d   = S_GAP;
        end else begin
          case (cnt_q[1:0])
            2'd0:    ld_buf_d[7:0]   = mem_din;
            2'd1:    ld_buf_d[15:8]  = mem_din;
            default: ld_buf_d[23:16] = mem_din;
          endcase
          cnt_d   = cnt_nx;
          mem_a_d = addr_nx;
        end
      end

      S_FETCH: begin
        fetch_line_d[{cnt_q, 3'b000} +: 8] = mem_din;
        if (cnt_q == last_q) begin
          fetch_done_d = 1'b1;
          state_d      = S_GAP;
        end else begin
          cnt_d   = cnt_nx;
          mem_a_d = addr_nx;
        end
      end

      S_GAP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      last_q     <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      size_q     <= '0;
      signed_q   <= 1'b0;
      ld_buf_q   <= '0;
      fetch_done <= 1'b0;
      st_done    <= 1'b0;
      ld_done    <= 1'b0;
      mem_wr     <= 1'b0;
      fetch_line <= '0;
      ld_data    <= '0;
      mem_dout   <= '0;
      mem_a      <= '0;
    end else if (rdy) begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      size_q     <= size_d;
      signed_q   <= signed_d;
      ld_buf_q   <= ld_buf_d;
      fetch_done <= fetch_done_d;
      st_done    <= st_done_d;
      ld_done    <= ld_done_d;
      mem_wr     <= mem_wr_d;
      fetch_line <= fetch_line_d;
      ld_data    <= ld_data_d;
      mem_dout   <= mem_dout_d;
      mem_a      <= mem_a_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter_line.sv
// Testbench for mem_arbiter_line (LINE_BYTES=64, ADDR_W=32).
module tb_mem_arbiter_line;

  localparam int LB = 64;

  logic          clk = 1'b0;
  logic          rst, rdy;
  logic          fetch_req;
  logic [31:0]   fetch_addr;
  logic          fetch_done;
  logic [8*LB-1:0] fetch_line;
  logic          st_req;
  logic [31:0]   st_addr, st_data;
  logic [1:0]    st_size;
  logic          st_done;
  logic          ld_req;
  logic [31:0]   ld_addr;
  logic [1:0]    ld_size;
  logic          ld_signed;
  logic          ld_done;
  logic [31:0]   ld_data;
  logic          io_full;
  logic [7:0]    mem_din, mem_dout;
  logic [31:0]   mem_a;
  logic          mem_wr;
  logic [2:0]    dbg_state;

  int tests = 0;
  int fails = 0;

  // expected RAM writes: {address, byte}
  logic [39:0] exp_q[$];

  typedef struct {
    logic        is_store;
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[19];

  mem_arbiter_line #(.LINE_BYTES(LB), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_done(fetch_done), .fetch_line(fetch_line),
    .st_req(st_req), .st_addr(st_addr), .st_data(st_data),
    .st_size(st_size), .st_done(st_done),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_size(ld_size),
    .ld_signed(ld_signed), .ld_done(ld_done), .ld_data(ld_data),
    .io_full(io_full),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a),
    .mem_wr(mem_wr), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- RAM model (64 KiB, low address bits) ----------------
  logic [7:0] ram [0:65535];
  assign mem_din = ram[mem_a[15:0]];
  always @(posedge clk) begin
    if (rdy && mem_wr) ram[mem_a[15:0]] <= mem_dout;
  end

  // ---------------- scoreboard for RAM writes ----------------
  always @(negedge clk) begin
    logic [39:0] e;
    if (rst && rdy && mem_wr) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_write: addr %h data %h, none expected", mem_a, mem_dout);
      end else begin
        e = exp_q.pop_front();
        if ({mem_a, mem_dout} !== e) begin
          fails++;
          $display("FAIL write: got addr %h data %h, expected addr %h data %h",
                   mem_a, mem_dout, e[39:8], e[7:0]);
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_line(input string name, input logic [8*LB-1:0] act, input logic [8*LB-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got low word %h expected low word %h", name, act[31:0], exp[31:0]);
    end
  endtask

  function automatic logic [7:0] pat(input int i);
    return 8'(i * 7 + 3);
  endfunction

  function automatic int nbytes(input logic [1:0] size);
    return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [8*LB-1:0] exp_line();
    logic [8*LB-1:0] l;
    for (int i = 0; i < LB; i++) l[8*i +: 8] = pat(i);
    return l;
  endfunction

  task automatic push_store(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] size);
    for (int k = 0; k < nbytes(size); k++)
      exp_q.push_back({addr + 32'(k), data[8*k +: 8]});
  endtask

  // ---------------- driver: one store or load ----------------
  task automatic do_access(input vec_t v, input int idx);
    int  n, cyc;
    bit  seen;
    n = nbytes(v.size);
    @(negedge clk);
    if (v.is_store) begin
      push_store(v.addr, v.data, v.size);
      st_req = 1'b1; st_addr = v.addr; st_data = v.data; st_size = v.size;
    end else begin
      ld_req = 1'b1; ld_addr = v.addr; ld_size = v.size; ld_signed = v.sgn;
    end
    cyc = 0; seen = 0;
    while (!seen && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) begin
        // request fields must be ignored after the accept edge
        st_data = ~st_data; st_addr = st_addr ^ 32'h55; st_size = st_size ^ 2'b01;
        ld_addr = ld_addr ^ 32'h55; ld_size = ld_size ^ 2'b01; ld_signed = ~ld_signed;
      end
      seen = v.is_store ? st_done : ld_done;
    end
    st_req = 1'b0; ld_req = 1'b0;
    tests++;
    if (!seen || cyc != n + 1) begin
      fails++;
      $display("FAIL vec%0d_latency: got %0d cycles (done seen %0d) expected %0d", idx, cyc, seen, n + 1);
    end
    if (!v.is_store) chk32($sformatf("vec%0d_ld_data", idx), ld_data, v.exp);
    @(posedge clk); #1;
    chk32($sformatf("vec%0d_done_pulse", idx), {31'd0, v.is_store ? st_done : ld_done}, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cyc, st_at, ld_at, f_at, st_n, ld_n, f_n, cnt;
    vec_t v;

    vecs[0]  = '{1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 2'd2, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 32'h0000_0100, 32'h0,         2'd2, 1'b0, 32'hDEAD_BEEF};
    vecs[2]  = '{1'b0, 32'h0000_0103, 32'h0,         2'd0, 1'b1, 32'hFFFF_FFDE};
    vecs[3]  = '{1'b0, 32'h0000_0101, 32'h0,         2'd1, 1'b0, 32'h0000_ADBE};
    vecs[4]  = '{1'b1, 32'h0000_0200, 32'h0000_0080, 2'd0, 1'b0, 32'h0};
    vecs[5]  = '{1'b0, 32'h0000_0200, 32'h0,         2'd0, 1'b1, 32'hFFFF_FF80};
    vecs[6]  = '{1'b0, 32'h0000_0200, 32'h0,         2'd0, 1'b0, 32'h0000_0080};
    vecs[7]  = '{1'b1, 32'h0000_0210, 32'h0000_8001, 2'd1, 1'b0, 32'h0};
    vecs[8]  = '{1'b0, 32'h0000_0210, 32'h0,         2'd1, 1'b1, 32'hFFFF_8001};
    vecs[9]  = '{1'b0, 32'h0000_0210, 32'h0,         2'd1, 1'b0, 32'h0000_8001};
    vecs[10] = '{1'b1, 32'h0000_0300, 32'h2200_0011, 2'd3, 1'b0, 32'h0};
    vecs[11] = '{1'b1, 32'h0000_0301, 32'hFFFF_1234, 2'd1, 1'b0, 32'h0};
    vecs[12] = '{1'b0, 32'h0000_0300, 32'h0,         2'd3, 1'b1, 32'h2212_3411};
    vecs[13] = '{1'b0, 32'h0000_0100, 32'h0,         2'd2, 1'b1, 32'hDEAD_BEEF};
    vecs[14] = '{1'b1, 32'hFFFF_FFFE, 32'h1234_5678, 2'd2, 1'b0, 32'h0};
    vecs[15] = '{1'b0, 32'hFFFF_FFFE, 32'h0,         2'd2, 1'b0, 32'h1234_5678};
    vecs[16] = '{1'b0, 32'h0000_0102, 32'h0,         2'd1, 1'b1, 32'hFFFF_DEAD};
    vecs[17] = '{1'b1, 32'h0000_0304, 32'hFFFF_FFA5, 2'd0, 1'b0, 32'h0};
    vecs[18] = '{1'b0, 32'h0000_0303, 32'h0,         2'd1, 1'b0, 32'h0000_A522};

    rst = 1'b1; rdy = 1'b1; io_full = 1'b0;
    fetch_req = 1'b0; fetch_addr = '0;
    st_req = 1'b0; st_addr = '0; st_data = '0; st_size = '0;
    ld_req = 1'b0; ld_addr = '0; ld_size = '0; ld_signed = 1'b0;

    // ---- reset ----
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk32("reset_mem_wr", {31'd0, mem_wr}, 32'd0);
    chk32("reset_dones", {29'd0, st_done, ld_done, fetch_done}, 32'd0);
    chk32("reset_mem_a", mem_a, 32'd0);
    chk32("reset_ld_data", ld_data, 32'd0);
    chk32("reset_state", {29'd0, dbg_state}, 32'd0);
    @(negedge clk) rst = 1'b1;

    // ---- table-driven stores and loads ----
    for (int i = 0; i < 19; i++) do_access(vecs[i], i);

    // ---- fill a line with a known pattern via word stores ----
    for (int k = 0; k < LB / 4; k++) begin
      v.is_store = 1'b1; v.addr = 32'h1200 + 32'(4 * k); v.size = 2'd2; v.sgn = 1'b0; v.exp = '0;
      v.data = {pat(4*k+3), pat(4*k+2), pat(4*k+1), pat(4*k)};
      do_access(v, 100 + k);
    end

    // ---- fetch at 0x1234 ----
    @(negedge clk);
    fetch_req = 1'b1; fetch_addr = 32'h1234;
    cyc = 0;
    while (!fetch_done && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) fetch_addr = 32'h5000;
    end
    fetch_req = 1'b0;
    chk32("fetch_latency", cyc, 32'd65);
    chk32("fetch_byte0", {24'd0, fetch_line[7:0]}, {24'd0, pat(0)});
    chk_line("fetch_line", fetch_line, exp_line());
    repeat (2) @(posedge clk);

    // ---- simultaneous requests ----
    @(negedge clk);
    push_store(32'h400, 32'hCAFE_F00D, 2'd2);
    st_req = 1'b1; st_addr = 32'h400; st_data = 32'hCAFE_F00D; st_size = 2'd2;
    ld_req = 1'b1; ld_addr = 32'h210; ld_size = 2'd1; ld_signed = 1'b1;
    fetch_req = 1'b1; fetch_addr = 32'h1234;
    cyc = 0; st_at = 0; ld_at = 0; f_at = 0; st_n = 0; ld_n = 0; f_n = 0;
    while (cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (st_done) begin st_n++; st_at = cyc; st_req = 1'b0; end
      if (ld_done) begin ld_n++; ld_at = cyc; ld_req = 1'b0; end
      if (fetch_done) begin f_n++; f_at = cyc; fetch_req = 1'b0; end
    end
    chk32("simul_st_at", st_at, 32'd5);
    chk32("simul_ld_at", ld_at, 32'd9);
    chk32("simul_f_at", f_at, 32'd75);
    chk32("simul_counts", {8'd0, 8'(st_n), 8'(ld_n), 8'(f_n)}, 32'h0001_0101);
    chk32("simul_ld_data", ld_data, 32'hFFFF_8001);
    chk_line("simul_fetch_line", fetch_line, exp_line());

    // ---- rdy low for 3 cycles mid-load ----
    @(negedge clk);
    ld_req = 1'b1; ld_addr = 32'h100; ld_size = 2'd2; ld_signed = 1'b0;
    cyc = 0;
    while (!ld_done && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 2) rdy = 1'b0;
      if (cyc == 4) chk32("frozen_mem_a", mem_a, 32'h101);
      if (cyc == 5) rdy = 1'b1;
    end
    ld_req = 1'b0;
    chk32("rdy_latency", cyc, 32'd8);
    chk32("rdy_ld_data", ld_data, 32'hDEAD_BEEF);
    repeat (2) @(posedge clk);

    // ---- async reset mid-fetch ----
    @(negedge clk);
    fetch_req = 1'b1; fetch_addr = 32'h1234;
    repeat (10) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk32("rst_outputs", {28'd0, mem_wr, st_done, ld_done, fetch_done}, 32'd0);
    chk32("rst_ld_data", ld_data, 32'd0);
    chk32("rst_mem_a", mem_a, 32'd0);
    chk32("rst_mem_dout", {24'd0, mem_dout}, 32'd0);
    chk32("rst_state", {29'd0, dbg_state}, 32'd0);
    chk_line("rst_fetch_line", fetch_line, '0);
    fetch_req = 1'b0;
    @(negedge clk);
    @(negedge clk) rst = 1'b1;
    cnt = 0;
    repeat (80) begin
      @(posedge clk); #1;
      if (fetch_done) cnt++;
    end
    chk32("rst_no_fetch_done", cnt, 32'd0);

    // ---- IO store with io_full ----
`ifdef MEM_IO_STALL_EN
    @(negedge clk);
    io_full = 1'b1;
    push_store(32'h30010, 32'h0BAD_F00D, 2'd2);
    st_req = 1'b1; st_addr = 32'h30010; st_data = 32'h0BAD_F00D; st_size = 2'd2;
    ld_req = 1'b1; ld_addr = 32'h100; ld_size = 2'd2; ld_signed = 1'b0;
    cnt = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (st_done || ld_done || dbg_state != 3'd0) cnt++;
    end
    chk32("io_stall_idle", cnt, 32'd0);
    io_full = 1'b0;
    cyc = 0; st_at = 0; ld_at = 0;
    while ((st_at == 0 || ld_at == 0) && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (st_done) begin st_at = cyc; st_req = 1'b0; end
      if (ld_done) begin ld_at = cyc; ld_req = 1'b0; end
    end
    chk32("io_stall_st_at", st_at, 32'd5);
    chk32("io_stall_ld_at", ld_at, 32'd11);
    chk32("io_stall_ld_data", ld_data, 32'hDEAD_BEEF);
`else
    io_full = 1'b1;
    v = '{1'b1, 32'h0003_0010, 32'h0BAD_F00D, 2'd2, 1'b0, 32'h0};
    do_access(v, 200);
    v = '{1'b0, 32'h0003_0010, 32'h0,         2'd2, 1'b0, 32'h0BAD_F00D};
    do_access(v, 201);
    io_full = 1'b0;
`endif

    repeat (2) @(posedge clk);
    chk32("writes_drained", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_arbiter_line.md
# mem_arbiter_line

Parametrised successor of the single-port memory controller: arbitrates store (ROB), load (LSB) and instruction-line fetch (icache) onto the byte-wide RAM port with fixed priority store > load > fetch. Serialises multi-byte accesses, assembles loads with correct sign/zero extension, and fills a configurable-width icache line. Sits between the core's memory clients and the top-level RAM/IO bus.

## Interface
- `LINE_BYTES`, 64, icache line size in bytes; power of two, 4..128.
- `ADDR_W`, 32, address width.
- `clk` in 1 — system clock, all state on rising edge.
- `rst` in 1 — asynchronous, active-low reset.
- `rdy` in 1 — global enable; low freezes all state and outputs.
- `fetch_req` in 1 — icache miss; held until `fetch_done`.
- `fetch_addr` in ADDR_W — miss PC; low log2(LINE_BYTES) bits ignored.
- `fetch_done` out 1 — one-cycle pulse, `fetch_line` valid.
- `fetch_line` out 8*LINE_BYTES — byte i at bits [8i+7:8i]; holds until next fetch starts.
- `st_req` in 1 — store request; held until `st_done`.
- `st_addr` in ADDR_W, `st_data` in 32, `st_size` in 2 — 0 byte, 1 half, 2/3 word.
- `st_done` out 1 — one-cycle pulse.
- `ld_req` in 1, `ld_addr` in ADDR_W, `ld_size` in 2 (as `st_size`), `ld_signed` in 1.
- `ld_done` out 1 — one-cycle pulse; `ld_data` out 32 valid with it, held until next load accept.
- `io_full` in 1 — IO output buffer full (used only with `MEM_IO_STALL_EN`).
- `mem_din` in 8, `mem_dout` out 8, `mem_a` out ADDR_W, `mem_wr` out 1 (1 = write).

## Operation
- States: IDLE, STORE, LOAD, FETCH, GAP.
- IDLE: sample requests each enabled edge; accept highest-priority asserted one. Byte count N = 1/2/4 from size, LINE_BYTES for fetch.
- STORE: byte k (little-endian, `st_data[8k+7:8k]`) driven on `mem_dout` with `mem_a = st_addr+k`, `mem_wr=1`, for k=0..N-1; then `mem_wr<=0`, `st_done<=1`, go GAP.
- LOAD: `mem_a = ld_addr+k`, `mem_wr=0`; byte k captured from `mem_din` one cycle after its address. After byte N-1 captured: `ld_data` = assembled bytes, bits above 8N filled with MSB of byte N-1 if `ld_signed`, else 0 (word ignores `ld_signed`); `ld_done<=1`; go GAP.
- FETCH: base = `fetch_addr` with low bits cleared; reads LINE_BYTES consecutive bytes into line buffer; `fetch_done<=1` after last capture; go GAP.
- GAP: one cycle, no accept, done pulse deasserts; lets requester drop `req`. Then IDLE.
- Request inputs other than `*_req` sampled only at accept; latched internally, later changes ignored.
- Arithmetic: addresses wrap modulo 2^ADDR_W; no alignment requirement for loads/stores.

## Timing
- RAM read latency 1: address at edge E, data valid on `mem_din` before E+1.
- Store of N bytes: accept edge E0; writes at E1..EN; `st_done` high in cycle after EN. Occupancy N+2 cycles incl. GAP.
- Load of N bytes: accept E0 drives first address; captures at E1..EN; `ld_done` high cycle after EN. Latency N+1 cycles req-to-done.
- Fetch: same as load with N = LINE_BYTES; latency LINE_BYTES+1.
- Simultaneous requests: loser waits in IDLE; never dropped. Store arriving during a fetch waits for fetch completion (no preemption).
- `rdy` low mid-access: no state, counter or output changes; `mem_wr` holds its value.
- Reset (any time, async): state IDLE; `fetch_done`, `st_done`, `ld_done`, `mem_wr` = 0; `ld_data`, `mem_dout`, `mem_a`, `fetch_line` = 0. Interrupted store may leave partial bytes written; no completion issued.

## Configuration
- `MEM_IO_STALL_EN` defined: store to IO space (`st_addr[17:16] == 2'b11`) is not accepted while `io_full`=1; it waits in IDLE and blocks lower-priority requests. Once started it is not stalled.
- Undefined: `io_full` ignored; IO stores accepted like any store.

## Test plan
- Store word 0xDEADBEEF to 0x100 -> writes EF,BE,AD,DE to 0x100..0x103 on consecutive edges; `st_done` 5 cycles after `st_req`.
- LB signed from byte 0x80 -> `ld_data`=0xFFFFFF80; LBU -> 0x00000080; LH signed of 0x8001 (bytes 01,80) -> 0xFFFF8001.
- Fetch at PC 0x1234 with LINE_BYTES=64 -> reads 0x1200..0x123F; `fetch_done` after 65 cycles; `fetch_line[7:0]` = byte at 0x1200.
- `st_req`, `ld_req`, `fetch_req` asserted same cycle -> order store, load, fetch; each separated by GAP; all three dones exactly once.
- `rdy` low for 3 cycles mid-load, and async reset mid-fetch -> load completes 3 cycles late with correct data; after reset all outputs 0, no `fetch_done`.
- With `MEM_IO_STALL_EN`, `io_full`=1, store to 0x30000 plus `ld_req` -> nothing accepted until `io_full`=0, then store first.
